// File: rtl/cnn_pkg.sv
// cnn_pkg: shared defaults and width helpers for the CNN pooling stage.
package cnn_pkg;

    localparam int DEF_DATA_W = 8;
    // SIGNED_DATA convention: 1 compares pixels as two's complement, 0 as unsigned
    localparam bit DEF_SIGNED_DATA = 1'b1;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_max2.sv
// cnn_max2: combinational two-input max; on a tie the common value comes out.
module cnn_max2 import cnn_pkg::*; #(
    parameter int DATA_W      = DEF_DATA_W,
    parameter bit SIGNED_DATA = DEF_SIGNED_DATA
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    logic a_gt;

    assign a_gt = SIGNED_DATA ? ($signed(a) > $signed(b)) : (a > b);
    assign y    = a_gt ? a : b;

endmodule

// File: rtl/cnn_maxpool_parallel.sv
// cnn_maxpool_parallel: 2x2 stride-2 max pool over a two-pixel-per-beat raster stream.
module cnn_maxpool_parallel import cnn_pkg::*; #(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter bit SIGNED_DATA = DEF_SIGNED_DATA,
    localparam int BPR        = IMG_W / 2,
    localparam int CW         = clog2_min1(BPR),
    localparam int RW         = clog2_min1(IMG_H / 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     out_col,
    output logic [RW-1:0]     out_row,
    output logic              frame_done
);

    localparam int HW = clog2_min1(IMG_H);

    logic [CW-1:0]     col_cnt;
    logic [HW-1:0]     row_cnt;
    logic [DATA_W-1:0] linebuf [BPR];
    logic [DATA_W-1:0] h, v;
    logic              col_last, row_last, odd;

    cnn_max2 #(.DATA_W(DATA_W), .SIGNED_DATA(SIGNED_DATA)) u_hmax (
        .a(in_a), .b(in_b), .y(h)
    );

    cnn_max2 #(.DATA_W(DATA_W), .SIGNED_DATA(SIGNED_DATA)) u_vmax (
        .a(linebuf[col_cnt]), .b(h), .y(v)
    );

    assign col_last = col_cnt == CW'(BPR - 1);
    assign row_last = row_cnt == HW'(IMG_H - 1);
    assign odd      = row_cnt[0];

    // Even rows always refill the buffer before the odd row reads it, so no reset is needed
    always_ff @(posedge clk) begin
        if (in_valid && !odd) linebuf[col_cnt] <= h;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_col    <= '0;
            out_row    <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= in_valid && odd;
            frame_done <= in_valid && odd && col_last && row_last;
            if (in_valid) begin
                col_cnt <= col_last ? '0 : col_cnt + 1'b1;
                if (col_last) row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                if (odd) begin
                    out_data <= v;
                    out_col  <= col_cnt;
                    out_row  <= RW'(row_cnt >> 1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cnn_maxpool_parallel.sv
// tb_cnn_maxpool_parallel: directed scoreboard bench over several pooling geometries.
module tb_cnn_maxpool_parallel;

    localparam int N = 5;
    localparam int WS [N] = '{4, 2, 2, 4, 8};
    localparam int HS [N] = '{2, 2, 2, 4, 8};
    localparam bit SS [N] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    typedef struct {
        int         id;
        logic [7:0] d;
        int         c;
        int         r;
        bit         f;
        int         at;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] iv = '0;
    logic [7:0]   ina = '0, inb = '0;
    logic [N-1:0] ov, fd;
    logic [7:0]   od  [N];
    logic [3:0]   oc  [N];
    logic [3:0]   orr [N];
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    exp_t         q [$];
    exp_t         e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : d
        localparam int CW = (WS[g] / 2 > 1) ? $clog2(WS[g] / 2) : 1;
        localparam int RW = (HS[g] / 2 > 1) ? $clog2(HS[g] / 2) : 1;
        logic [CW-1:0] c;
        logic [RW-1:0] r;
        cnn_maxpool_parallel #(
            .DATA_W(8), .IMG_W(WS[g]), .IMG_H(HS[g]), .SIGNED_DATA(SS[g])
        ) dut (
            .clk(clk), .rst(rst), .in_valid(iv[g]), .in_a(ina), .in_b(inb),
            .out_valid(ov[g]), .out_data(od[g]), .out_col(c), .out_row(r),
            .frame_done(fd[g])
        );
        assign oc[g]  = 4'(c);
        assign orr[g] = 4'(r);
    end

    // Monitor: every presented output must match the oldest expectation, cycle-exact
    always @(negedge clk) begin
        if (rst) for (int g = 0; g < N; g++) begin
            if (fd[g] && !ov[g]) begin
                total++;
                bad++;
                $display("FAIL fd_without_valid dut%0d got fd=1 valid=0 want fd=0", g);
            end
            if (ov[g]) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out dut%0d got d=%0h col=%0d row=%0d want no output", g, od[g], oc[g], orr[g]);
                end else begin
                    e = q.pop_front();
                    if (e.id != g || od[g] !== e.d || int'(oc[g]) != e.c || int'(orr[g]) != e.r || fd[g] !== e.f || cyc != e.at) begin
                        bad++;
                        $display("FAIL pooled_out got dut%0d d=%0h col=%0d row=%0d fd=%0b cyc=%0d want dut%0d d=%0h col=%0d row=%0d fd=%0b cyc=%0d",
                                 g, od[g], oc[g], orr[g], fd[g], cyc, e.id, e.d, e.c, e.r, e.f, e.at);
                    end
                end
            end
        end
    end

    function automatic logic [7:0] mx(input logic [7:0] a, input logic [7:0] b, input bit s);
        if (s) return ($signed(a) >= $signed(b)) ? a : b;
        return (a >= b) ? a : b;
    endfunction

    task automatic beat(input logic [N-1:0] m, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        iv  = m;
        ina = a;
        inb = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            iv = '0;
        end
    endtask

    task automatic expect_out(input int g, input logic [7:0] dv, input int c, input int r, input bit f);
        q.push_back('{g, dv, c, r, f, cyc + 1});
    endtask

    // Random frame; each odd-row beat expects the max of its whole 2x2 block. lim<0 = full frame.
    task automatic send_frame(input int g, input int gap, input int lim);
        logic [7:0] p [8][8];
        int w, h, n;
        w = WS[g];
        h = HS[g];
        n = 0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) p[r][c] = 8'($urandom);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w / 2; c++) begin
                if (lim >= 0 && n >= lim) return;
                if (gap > 0) idle($urandom_range(1, gap));
                beat(N'(1) << g, p[r][2*c], p[r][2*c+1]);
                n++;
                if (r % 2 == 1)
                    expect_out(g, mx(mx(p[r-1][2*c], p[r-1][2*c+1], SS[g]), mx(p[r][2*c], p[r][2*c+1], SS[g]), SS[g]),
                               c, r / 2, r == h - 1 && c == w / 2 - 1);
            end
        end
    endtask

    initial begin
        iv = '1;
        repeat (3) begin
            @(negedge clk);
            ina = 8'($urandom);
            inb = 8'($urandom);
        end
        for (int g = 0; g < N; g++) begin
            total++;
            if (ov[g] !== 1'b0 || od[g] !== 8'h00 || oc[g] !== 4'h0 || orr[g] !== 4'h0 || fd[g] !== 1'b0) begin
                bad++;
                $display("FAIL reset_state dut%0d got v=%0b d=%0h col=%0d row=%0d fd=%0b want all 0", g, ov[g], od[g], oc[g], orr[g], fd[g]);
            end
        end
        @(negedge clk);
        iv  = '0;
        rst = 1'b1;
        // 4x2 unsigned: row 0 alone must not produce output
        beat(5'b00001, 8'd1, 8'd5);
        @(posedge clk);
        #1;
        total++;
        if (ov !== '0) begin
            bad++;
            $display("FAIL row0_quiet got valid=%b want 0", ov);
        end
        beat(5'b00001, 8'd3, 8'd2);
        @(posedge clk);
        #1;
        total++;
        if (ov !== '0) begin
            bad++;
            $display("FAIL row0_quiet2 got valid=%b want 0", ov);
        end
        beat(5'b00001, 8'd4, 8'd0);
        expect_out(0, 8'd5, 0, 0, 1'b0);
        beat(5'b00001, 8'd7, 8'd9);
        expect_out(0, 8'd9, 1, 0, 1'b1);
        idle(2);
        // 2x2 signed vs unsigned on identical stimulus
        beat(5'b00110, 8'h80, 8'h03);
        beat(5'b00110, 8'hFF, 8'h02);
        expect_out(1, 8'h03, 0, 0, 1'b1);
        expect_out(2, 8'hFF, 0, 0, 1'b1);
        idle(2);
        send_frame(3, 3, -1);
        idle(2);
        send_frame(3, 0, -1);
        send_frame(3, 0, -1);
        idle(2);
        // 8x8: abandon after 3 beats of row 1, reset, then a clean frame
        send_frame(4, 0, 7);
        idle(1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        send_frame(4, 0, -1);
        idle(4);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending_outputs got missing=%0d want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cnn_maxpool_parallel.md
Name: cnn_maxpool_parallel

Overview:
- 2x2, stride-2 max-pooling stage placed directly downstream of cnn_parallel.
- Consumes the two-pixel-per-cycle feature-map stream that cnn_parallel emits on y0/y1: even column on in_a, odd column on in_b, same row.
- Emits one pooled pixel per input beat on odd rows. Raster-order position counters and a half-width line buffer track where each beat falls in the frame.

Parameters:
- DATA_W, 8, pixel width in bits (matches y0/y1).
- IMG_W, 8, feature-map width in pixels; must be even and >= 2. Beats per row BPR = IMG_W/2.
- IMG_H, 8, feature-map height in rows; must be even and >= 2.
- SIGNED_DATA, 1, 1 = compare pixels as two's-complement, 0 = unsigned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat qualifier for in_a/in_b.
- in_a  in  DATA_W  pixel at even column 2c.
- in_b  in  DATA_W  pixel at odd column 2c+1.
- out_valid  out  1  out_data is a valid pooled pixel.
- out_data  out  DATA_W  pooled pixel, max of a 2x2 block.
- out_col  out  clog2(BPR) (min 1)  pooled column index.
- out_row  out  clog2(IMG_H/2) (min 1)  pooled row index.
- frame_done  out  1  one-cycle pulse coincident with the last pooled pixel of a frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, out_col=0, out_row=0, frame_done=0.
  - col_cnt=0, row_cnt=0.
  - Line-buffer contents are don't-care, because even rows always overwrite them before use.
- Horizontal max per accepted beat: h = max(in_a, in_b), combinational, compared per SIGNED_DATA. On a tie the common value is used.
- Input stall: beats are accepted only when in_valid=1. With in_valid=0, all counters and the line buffer hold, and out_valid/frame_done are 0 next cycle.
- Even row (row_cnt[0]=0):
  - linebuf[col_cnt] <= h.
  - No output.
- Odd row (row_cnt[0]=1):
  - Registered outputs next cycle (latency = 1 clk from accepted beat): out_data <= max(linebuf[col_cnt], h), out_valid <= 1, out_col <= col_cnt, out_row <= row_cnt>>1.
- Counters:
  - col_cnt increments per accepted beat and wraps BPR-1 -> 0.
  - On wrap, row_cnt increments and wraps IMG_H-1 -> 0.
- frame_done:
  - Asserted in the output cycle of the beat at col_cnt=BPR-1, row_cnt=IMG_H-1.
  - The counters return to 0 on that same beat.
  - A following frame may start on the very next cycle with no gap.
- Output timing: out_valid and out_data are registered. out_data holds its last value when out_valid=0.
- Reset mid-frame: the partial frame is discarded and the next accepted beat is treated as row 0, col 0.
- No backpressure: the consumer must accept every out_valid cycle.
- Output rate: (IMG_W/2)*(IMG_H/2) pooled pixels per frame.

Decomposition:
- Package cnn_pkg holds:
  - DATA_W default;
  - the SIGNED_DATA compare convention;
  - a clog2 helper function for the counter widths.
- One sub-module, cnn_max2: a combinational two-input max, parameterised on DATA_W and SIGNED_DATA. Instantiate it twice: once for the horizontal max, once for the vertical max.
- Line buffer: register array of BPR x DATA_W.

Test Plan:
- Reset: hold rst=0 with random in_a/in_b and in_valid=1 -> all outputs 0. Release rst, then drive a 2nd-row beat -> no out_valid until a full row 0 has been fed.
- Basic pooling, IMG_W=4, IMG_H=2, unsigned. Row 0 beats (1,5),(3,2); row 1 beats (4,0),(7,9):
  - first output: out_data=5, out_col=0;
  - second output: out_data=9, out_col=1, with frame_done=1 on the same cycle;
  - each output one clk after its row-1 beat.
- Signed compare, SIGNED_DATA=1. Beats 0x80 (-128), 0x03 over 0xFF (-1), 0x02 -> out_data=0x03. With SIGNED_DATA=0, the same stimulus gives out_data=0xFF.
- Stalls, IMG_W=4, IMG_H=4. Insert in_valid=0 gaps of 1-3 cycles between random beats -> exactly 4 outputs, matching a reference model, at (row,col) = (0,0),(0,1),(1,0),(1,1). frame_done only at (1,1).
- Back-to-back frames: two 4x4 frames with no gap -> 8 outputs and frame_done pulses on output #4 and #8. The second frame's values are unaffected by the first.
- Reset mid-frame: assert rst=0 after 3 beats of row 1 of an 8x8 frame, then feed a full frame -> exactly 16 outputs, starting at out_row=0, out_col=0, with values equal to the model of the new frame only.
